// File: rtl/neuron_seq_pkg.sv
// Shared definitions for the neuron timestep sequencer: default geometry and
// the sequencer state encoding.
package neuron_seq_pkg;

  localparam int DEFAULT_NUM_NEURONS = 256;
  localparam int DEFAULT_NUM_AXONS   = 256;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    INTEGRATE  = 3'd2,
    WRITE      = 3'd3,
    SPIKE_WAIT = 3'd4,
    NEXT       = 3'd5,
    DONE       = 3'd6
  } seq_state_e;

endpackage

// File: rtl/axon_scan_counter.sv
// Axon scan counter: sweeps 0..NUM_AXONS-1 once per neuron and flags the last
// axon so the sequencer can leave INTEGRATE without the index ever wrapping.
module axon_scan_counter
  import neuron_seq_pkg::*;
#(
  parameter  int NUM_AXONS = DEFAULT_NUM_AXONS,
  localparam int AW        = $clog2(NUM_AXONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          count_en,
  output logic [AW-1:0] count,
  output logic          last
);

  assign last = (count == AW'(NUM_AXONS - 1));

  // Axon index: held at zero by start, otherwise steps and returns to zero after the last axon
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= AW'(0);
    end else if (start) begin
      count <= AW'(0);
    end else if (count_en) begin
      count <= last ? AW'(0) : count + AW'(1);
    end
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Timestep sequencer: for every neuron, loads the stored potential, scans all
// axons into the integrator, writes the potential back and offers any spike.
module neuron_sequencer
  import neuron_seq_pkg::*;
#(
  parameter  int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter  int NUM_AXONS   = DEFAULT_NUM_AXONS,
  localparam int NW          = $clog2(NUM_NEURONS),
  localparam int AW          = $clog2(NUM_AXONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] axon_spikes,
  input  logic [NUM_AXONS-1:0] synapses,
  input  logic                 spike_in,
  input  logic                 spike_ready,
  output logic [NW-1:0]        neuron_index,
  output logic [AW-1:0]        axon_index,
  output logic                 integrator_reg_en,
  output logic                 write_current_potential,
  output logic                 next_neuron,
  output logic                 potential_we,
  output logic                 spike_valid,
  output logic [NW-1:0]        spike_neuron,
  output logic                 busy,
  output logic                 done,
  output logic                 tick_overrun
);

  seq_state_e state_r;
  logic       spike_pending_r;
  logic       scan_start_s;
  logic       scan_en_s;
  logic       axon_last_s;

  assign scan_start_s = (state_r != INTEGRATE);
  assign scan_en_s    = (state_r == INTEGRATE);
  assign spike_valid  = spike_pending_r;

  axon_scan_counter #(
    .NUM_AXONS (NUM_AXONS)
  ) u_axon_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (scan_start_s),
    .count_en (scan_en_s),
    .count    (axon_index),
    .last     (axon_last_s)
  );

  // Integrator enable: unconditional while loading, otherwise gated by spike and synapse at the scanned axon
  always_comb begin
    integrator_reg_en = 1'b0;
    case (state_r)
      LOAD:      integrator_reg_en = 1'b1;
      INTEGRATE: integrator_reg_en = axon_spikes[axon_index] & synapses[axon_index];
      default:   integrator_reg_en = 1'b0;
    endcase
  end

  // Sequencer FSM; each strobe is set on entry to its state and cleared on exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                 <= IDLE;
      neuron_index            <= NW'(0);
      spike_neuron            <= NW'(0);
      spike_pending_r         <= 1'b0;
      write_current_potential <= 1'b0;
      next_neuron             <= 1'b0;
      potential_we            <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      tick_overrun            <= 1'b0;
    end else begin
      // A tick during DONE is still an overrun: the pulse lands in the following IDLE cycle
      tick_overrun <= tick & (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (tick) begin
            neuron_index            <= NW'(0);
            write_current_potential <= 1'b1;
            busy                    <= 1'b1;
            state_r                 <= LOAD;
          end
        end
        LOAD: begin
          write_current_potential <= 1'b0;
          state_r                 <= INTEGRATE;
        end
        INTEGRATE: begin
          if (axon_last_s) begin
            potential_we <= 1'b1;
            state_r      <= WRITE;
          end
        end
        WRITE: begin
          potential_we    <= 1'b0;
          spike_pending_r <= spike_in;
          if (spike_in) begin
            spike_neuron <= neuron_index;
            state_r      <= SPIKE_WAIT;
          end else begin
            next_neuron <= 1'b1;
            state_r     <= NEXT;
          end
        end
        SPIKE_WAIT: begin
          if (spike_ready) begin
            spike_pending_r <= 1'b0;
            next_neuron     <= 1'b1;
            state_r         <= NEXT;
          end
        end
        NEXT: begin
          next_neuron <= 1'b0;
          if (neuron_index == NW'(NUM_NEURONS - 1)) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            neuron_index            <= neuron_index + NW'(1);
            write_current_potential <= 1'b1;
            state_r                 <= LOAD;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          spike_pending_r         <= 1'b0;
          write_current_potential <= 1'b0;
          next_neuron             <= 1'b0;
          potential_we            <= 1'b0;
          busy                    <= 1'b0;
          done                    <= 1'b0;
          state_r                 <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer (4 neurons x 4 axons): cycle-exact
// expected outputs come from a timeline model built from the timestep rules.
module tb_neuron_sequencer;
  import neuron_seq_pkg::*;

  localparam int TN = 4;
  localparam int TA = 4;
  localparam int NW = $clog2(TN);
  localparam int AW = $clog2(TA);
  localparam int BASE_LAT = TN * (TA + 3) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          spike_in = 1'b0;
  logic          spike_ready = 1'b0;
  logic [TA-1:0] axon_spikes = '0;
  logic [TA-1:0] synapses = '0;
  logic [NW-1:0] neuron_index;
  logic [NW-1:0] spike_neuron;
  logic [AW-1:0] axon_index;
  logic          integrator_reg_en, write_current_potential, next_neuron;
  logic          potential_we, spike_valid, busy, done, tick_overrun;

  always #5 clk = ~clk;

  neuron_sequencer #(.NUM_NEURONS(TN), .NUM_AXONS(TA)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .axon_spikes(axon_spikes),
    .synapses(synapses), .spike_in(spike_in), .spike_ready(spike_ready),
    .neuron_index(neuron_index), .axon_index(axon_index),
    .integrator_reg_en(integrator_reg_en),
    .write_current_potential(write_current_potential),
    .next_neuron(next_neuron), .potential_we(potential_we),
    .spike_valid(spike_valid), .spike_neuron(spike_neuron), .busy(busy),
    .done(done), .tick_overrun(tick_overrun)
  );

  typedef struct {
    int   ni; int ai; logic ire; logic wcp; logic nn; logic we; logic sv;
    int   sn; logic bsy; logic dn; logic ovr;
  } exp_t;

  typedef struct {
    logic [TA-1:0] aspk; logic [TA-1:0] syn; logic [TN-1:0] spk; int wt;
    int ovr_at; int abort_at; int lat; int nn; int we; int sv; int ire; int ovr;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // model / run bookkeeping
  logic [TA-1:0] aspk;
  logic [TA-1:0] syn_mem [TN];
  int   rel, ovr_at, abort_at, last_ni, last_sn;
  bit   aborted, ovr_due, tick_en;
  int   seen_done_at, cnt_done, cnt_nn, cnt_we, cnt_sv, cnt_ire, cnt_ovr;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s (rel cycle %0d): got %0d, expected %0d", name, rel, act, req);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk("neuron_index", int'(neuron_index), e.ni);
    chk("axon_index", int'(axon_index), e.ai);
    chk("integrator_reg_en", int'(integrator_reg_en), int'(e.ire));
    chk("write_current_potential", int'(write_current_potential), int'(e.wcp));
    chk("next_neuron", int'(next_neuron), int'(e.nn));
    chk("potential_we", int'(potential_we), int'(e.we));
    chk("spike_valid", int'(spike_valid), int'(e.sv));
    chk("spike_neuron", int'(spike_neuron), e.sn);
    chk("busy", int'(busy), int'(e.bsy));
    chk("done", int'(done), int'(e.dn));
    chk("tick_overrun", int'(tick_overrun), int'(e.ovr));
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{default: 0};
    e.ni = last_ni;
    return e;
  endfunction

  function automatic exp_t base(input int n);
    exp_t e;
    e = '{default: 0};
    e.ni = n;
    e.bsy = 1'b1;
    return e;
  endfunction

  // Asynchronous reset mid-cycle: outputs must clear without a clock edge
  task automatic do_reset();
    exp_t z;
    z = '{default: 0};
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_outputs(z);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tick = rb(); spike_in = rb(); spike_ready = rb();
      #1 chk_outputs(z);
    end
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b1;
    last_ni = 0; last_sn = 0; ovr_due = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check 1 time unit later
  task automatic cyc(input exp_t e_in, input logic spk, input logic rdy);
    exp_t e;
    e = e_in;
    if (aborted) return;
    if (rel == abort_at) begin
      do_reset();
      aborted = 1'b1;
      return;
    end
    tick = tick_en && (rel == 0 || rel == ovr_at);
    spike_in = spk;
    spike_ready = rdy;
    axon_spikes = aspk;
    synapses = syn_mem[e.ni];
    e.ovr = ovr_due;
    if (e.sv) last_sn = e.ni;
    e.sn = last_sn;
    #1 chk_outputs(e);
    if (done && seen_done_at < 0) seen_done_at = rel;
    cnt_done += int'(done); cnt_nn += int'(next_neuron); cnt_we += int'(potential_we);
    cnt_sv += int'(spike_valid); cnt_ire += int'(integrator_reg_en);
    cnt_ovr += int'(tick_overrun);
    ovr_due = tick && e.bsy;
    rel++;
    @(negedge clk);
  endtask

  // Timeline of one timestep: per neuron LOAD, TA axons, WRITE, optional wait, NEXT
  task automatic run_tick(input vec_t v);
    exp_t e;
    rel = 0; aborted = 1'b0; tick_en = 1'b1;
    abort_at = v.abort_at; ovr_at = v.ovr_at; aspk = v.aspk;
    seen_done_at = -1;
    cnt_done = 0; cnt_nn = 0; cnt_we = 0; cnt_sv = 0; cnt_ire = 0; cnt_ovr = 0;
    cyc(idle_exp(), rb(), rb());
    for (int n = 0; n < TN; n++) begin
      e = base(n); e.ire = 1'b1; e.wcp = 1'b1;
      cyc(e, rb(), rb());
      for (int a = 0; a < TA; a++) begin
        e = base(n); e.ai = a; e.ire = aspk[a] & syn_mem[n][a];
        cyc(e, rb(), rb());
      end
      e = base(n); e.we = 1'b1;
      cyc(e, v.spk[n], rb());
      if (v.spk[n]) begin
        for (int w = 0; w <= v.wt; w++) begin
          e = base(n); e.sv = 1'b1;
          cyc(e, rb(), (w == v.wt));
        end
      end
      e = base(n); e.nn = 1'b1;
      cyc(e, rb(), rb());
    end
    e = base(TN - 1); e.dn = 1'b1;
    cyc(e, rb(), rb());
    if (!aborted) last_ni = TN - 1;
    cyc(idle_exp(), rb(), rb());
    if (!aborted) begin
      chk("done_latency", seen_done_at, v.lat);
      chk("next_neuron_pulses", cnt_nn, v.nn);
      chk("potential_we_pulses", cnt_we, v.we);
      chk("spike_valid_cycles", cnt_sv, v.sv);
      chk("integrator_en_cycles", cnt_ire, v.ire);
      chk("tick_overrun_pulses", cnt_ovr, v.ovr);
    end
  endtask

  task automatic run_idle(input int ncyc);
    tick_en = 1'b0; aborted = 1'b0; abort_at = -1; ovr_at = -1;
    cnt_done = 0;
    for (int k = 0; k < ncyc; k++) cyc(idle_exp(), rb(), rb());
  endtask

  vec_t tbl [6];
  vec_t v;
  int   nsp;

  initial begin
    tbl[0] = '{aspk:4'b0000, syn:4'b0000, spk:4'b0000, wt:0, ovr_at:-1, abort_at:-1,
               lat:29, nn:4, we:4, sv:0, ire:4, ovr:0};
    tbl[1] = '{aspk:4'b1010, syn:4'b0011, spk:4'b0000, wt:0, ovr_at:-1, abort_at:-1,
               lat:29, nn:4, we:4, sv:0, ire:8, ovr:0};
    tbl[2] = '{aspk:4'b0000, syn:4'b1111, spk:4'b0100, wt:3, ovr_at:-1, abort_at:-1,
               lat:33, nn:4, we:4, sv:4, ire:4, ovr:0};
    tbl[3] = '{aspk:4'b1111, syn:4'b0101, spk:4'b0000, wt:0, ovr_at:10, abort_at:-1,
               lat:29, nn:4, we:4, sv:0, ire:12, ovr:1};
    tbl[4] = '{aspk:4'b1100, syn:4'b0110, spk:4'b1001, wt:0, ovr_at:-1, abort_at:-1,
               lat:31, nn:4, we:4, sv:2, ire:8, ovr:0};
    tbl[5] = '{aspk:4'b1111, syn:4'b1111, spk:4'b0000, wt:0, ovr_at:29, abort_at:-1,
               lat:29, nn:4, we:4, sv:0, ire:20, ovr:1};

    last_ni = 0; last_sn = 0; ovr_due = 1'b0; rel = 0;
    abort_at = -1; ovr_at = -1; aspk = '0;
    for (int n = 0; n < TN; n++) syn_mem[n] = '0;

    @(negedge clk);
    do_reset();
    run_idle(2);

    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < TN; n++) syn_mem[n] = tbl[i].syn;
      run_tick(tbl[i]);
    end

    // reset during neuron 1 INTEGRATE: no done afterwards, then a clean restart
    v = tbl[1];
    v.abort_at = 10;
    run_tick(v);
    run_idle(5);
    chk("no_done_after_reset", cnt_done, 0);
    for (int n = 0; n < TN; n++) syn_mem[n] = tbl[0].syn;
    run_tick(tbl[0]);

    for (int r = 0; r < 10; r++) begin
      v.aspk = 4'($urandom);
      v.syn = 4'b0000;
      v.spk = 4'($urandom);
      v.wt = int'($urandom_range(0, 3));
      v.abort_at = -1;
      nsp = $countones(v.spk);
      v.lat = BASE_LAT + nsp * (1 + v.wt);
      v.nn = TN; v.we = TN; v.sv = nsp * (1 + v.wt);
      v.ire = TN;
      for (int n = 0; n < TN; n++) begin
        syn_mem[n] = 4'($urandom);
        v.ire += $countones(v.aspk & syn_mem[n]);
      end
      if (rb()) begin
        v.ovr_at = int'($urandom_range(1, v.lat));
        v.ovr = 1;
      end else begin
        v.ovr_at = -1;
        v.ovr = 0;
      end
      run_tick(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 256, meaning the number of neurons processed per tick (at least 2).
REQ-002 The block SHALL have parameter NUM_AXONS, default 256, meaning the number of axons scanned per neuron (at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tick, input, 1 bit: single-cycle start-of-timestep pulse.
REQ-006 The block SHALL have port axon_spikes, input, NUM_AXONS bits: spikes pending this tick, one bit per axon.
REQ-007 The block SHALL have port synapses, input, NUM_AXONS bits: connectivity row of the current neuron, async-read.
REQ-008 The block SHALL have port spike_in, input, 1 bit: threshold result from the neuron datapath.
REQ-009 The block SHALL have port spike_ready, input, 1 bit: downstream router accepts the spike.
REQ-010 The block SHALL have port neuron_index, output, clog2(NUM_NEURONS) bits: neuron address for the parameter/potential memory.
REQ-011 The block SHALL have port axon_index, output, clog2(NUM_AXONS) bits: axon address for the axon-type (instruction) lookup.
REQ-012 The block SHALL have port integrator_reg_en, output, 1 bit: integrator register enable.
REQ-013 The block SHALL have port write_current_potential, output, 1 bit: forces zero weight while the stored potential is loaded.
REQ-014 The block SHALL have port next_neuron, output, 1 bit: single-cycle pulse between neurons.
REQ-015 The block SHALL have port potential_we, output, 1 bit: write enable for write_potential at neuron_index.
REQ-016 The block SHALL have port spike_valid, output, 1 bit: spike offered to the router.
REQ-017 The block SHALL have port spike_neuron, output, clog2(NUM_NEURONS) bits: index of the neuron that spiked.
REQ-018 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-019 The block SHALL have port done, output, 1 bit: single-cycle pulse at the end of a tick.
REQ-020 The block SHALL have port tick_overrun, output, 1 bit: single-cycle pulse when a tick arrives while busy.

Function
REQ-021 The state machine SHALL have the states IDLE, LOAD, INTEGRATE, WRITE, SPIKE_WAIT, NEXT and DONE.
REQ-022 In IDLE, when tick=1, the block SHALL clear neuron_index to 0 and move to LOAD.
REQ-023 In LOAD (1 cycle), write_current_potential=1, integrator_reg_en=1 and axon_index=0; the next state SHALL be INTEGRATE.
REQ-024 INTEGRATE SHALL last exactly NUM_AXONS cycles, with axon_index stepping 0 to NUM_AXONS-1.
REQ-025 In INTEGRATE, integrator_reg_en SHALL equal axon_spikes[axon_index] AND synapses[axon_index], and write_current_potential=0.
REQ-026 After axon NUM_AXONS-1, the next state SHALL be WRITE; axon_index SHALL reset to 0 and never wrap mid-neuron.
REQ-027 In WRITE (1 cycle), potential_we=1 and spike_in SHALL be registered into spike_pending.
REQ-028 From WRITE, the next state SHALL be SPIKE_WAIT if spike_in=1, else NEXT.
REQ-029 In SPIKE_WAIT, spike_valid=1 and spike_neuron=neuron_index; both SHALL stay stable until spike_ready=1, then the next state SHALL be NEXT.
REQ-030 spike_ready=1 in the first SPIKE_WAIT cycle SHALL give a 1-cycle handshake.
REQ-031 In NEXT (1 cycle), next_neuron=1.
REQ-032 From NEXT, if neuron_index = NUM_NEURONS-1 the next state SHALL be DONE; otherwise neuron_index increments and the next state SHALL be LOAD.
REQ-033 In DONE (1 cycle), done=1 and the next state SHALL be IDLE.
REQ-034 neuron_index SHALL be held constant from LOAD through NEXT of each neuron.
REQ-035 With no spikes, tick-to-done latency SHALL be NUM_NEURONS*(NUM_AXONS+3)+1 cycles.
REQ-036 Each spike SHALL add 1 cycle, plus 1 cycle per cycle spike_ready is low.
REQ-037 A tick while busy=1 SHALL be ignored with a tick_overrun pulse; a tick in the DONE cycle counts as busy.
REQ-038 Every strobe output (integrator_reg_en, write_current_potential, next_neuron, potential_we, spike_valid, done, tick_overrun) SHALL be 0 in any state not listed for it.

Reset
REQ-039 While rst_n=0, the state SHALL be IDLE, neuron_index, axon_index and spike_neuron SHALL be 0, spike_pending SHALL be 0, and all strobes and busy SHALL be 0, regardless of clk.
REQ-040 A reset mid-tick SHALL abort the timestep with no done pulse and no further potential_we.

Structure
REQ-041 The state encodings and the NUM_NEURONS/NUM_AXONS defaults SHALL live in a shared package (neuron_seq_pkg) used by the core top and the testbench.
REQ-042 The axon-scan counter SHALL be one sub-module, axon_scan_counter, with start, count-enable and last outputs; all other logic SHALL stay in neuron_sequencer.

Verification
REQ-043 Scenario: NUM_NEURONS=4, NUM_AXONS=4, axon_spikes=0, spike_in=0; tick -> done 29 cycles later, 4 next_neuron pulses, 4 potential_we pulses, 0 spike_valid.
REQ-044 Scenario: axon_spikes=4'b1010, synapses=4'b0011 -> integrator_reg_en high only at axon_index 1 of each INTEGRATE phase, plus every LOAD cycle.
REQ-045 Scenario: spike_in=1 at neuron 2 with spike_ready held low for 3 cycles -> spike_valid held 4 cycles, spike_neuron=2 stable, done at cycle 33.
REQ-046 Scenario: second tick at cycle 10 of a run -> tick_overrun pulses once, the run completes unchanged, done at cycle 29.
REQ-047 Scenario: rst_n low during neuron 1 INTEGRATE -> all outputs 0 asynchronously, no done pulse; a later tick restarts from neuron_index 0.
